// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared types for the two-master MMIO arbiter.
package mmio_arb_pkg;
    localparam int NUM_MASTERS = 2;
    typedef enum logic [1:0] {ARB, LOCKED0, LOCKED1} arb_state_t;
    typedef logic master_id_t;
endpackage

// File: rtl/mmio_rr_pick.sv
// mmio_rr_pick: two-way round-robin pick; the pointer only matters when both request.
module mmio_rr_pick
    import mmio_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] valid,
    input  master_id_t             pointer,
    output logic [NUM_MASTERS-1:0] grant,
    output master_id_t             grant_id
);
    always_comb begin
        grant_id = (&valid) ? pointer : valid[1] & ~valid[0];
        grant    = (|valid) ? (grant_id ? 2'b10 : 2'b01) : '0;
    end
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares one single-cycle MMIO slave between two masters with
// round-robin arbitration, bounded locking and a depth-1 response pipeline.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32,
    parameter int LOCK_MAX   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_m0_valid,
    input  logic                  i_m0_read,
    input  logic [ADDR_WIDTH-1:0] i_m0_addr,
    input  logic [DATA_WIDTH-1:0] i_m0_wdata,
    input  logic [3:0]            i_m0_byte_we,
    input  logic                  i_m0_lock,
    output logic                  o_m0_ready,
    output logic                  o_m0_rvalid,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    input  logic                  i_m1_valid,
    input  logic                  i_m1_read,
    input  logic [ADDR_WIDTH-1:0] i_m1_addr,
    input  logic [DATA_WIDTH-1:0] i_m1_wdata,
    input  logic [3:0]            i_m1_byte_we,
    input  logic                  i_m1_lock,
    output logic                  o_m1_ready,
    output logic                  o_m1_rvalid,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic [ADDR_WIDTH-1:0] o_s_addr,
    output logic [DATA_WIDTH-1:0] o_s_wdata,
    output logic [3:0]            o_s_byte_we,
    output logic                  o_s_read_en,
    input  logic [DATA_WIDTH-1:0] i_s_rdata
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t            state, state_d;
    master_id_t            ptr, ptr_d, pick_id, gnt_id, lock_id, resp_id;
    logic [CW-1:0]         cnt, cnt_d;
    logic [1:0]            req, pick_gnt, gnt;
    logic                  locked, cmd, resp_valid, resp_read, rsp_on;
    logic                  sel_read, sel_lock;
    logic [ADDR_WIDTH-1:0] sel_addr, addr_q;
    logic [DATA_WIDTH-1:0] sel_wdata, wdata_q;
    logic [3:0]            sel_be;

    assign req = {i_m1_valid, i_m0_valid};

    mmio_rr_pick u_pick (
        .valid    (req),
        .pointer  (ptr),
        .grant    (pick_gnt),
        .grant_id (pick_id)
    );

    // Grant is forced off during reset so the slave sees no strobe in that cycle.
    always_comb begin
        locked    = state != ARB;
        lock_id   = state == LOCKED1;
        gnt_id    = locked ? lock_id : pick_id;
        gnt       = i_rst ? 2'b00 : locked ? (req & (lock_id ? 2'b10 : 2'b01)) : pick_gnt;
        cmd       = |gnt;
        sel_read  = gnt_id ? i_m1_read : i_m0_read;
        sel_lock  = gnt_id ? i_m1_lock : i_m0_lock;
        sel_addr  = gnt_id ? i_m1_addr : i_m0_addr;
        sel_wdata = gnt_id ? i_m1_wdata : i_m0_wdata;
        sel_be    = gnt_id ? i_m1_byte_we : i_m0_byte_we;
    end

    assign o_m0_ready  = gnt[0];
    assign o_m1_ready  = gnt[1];
    assign o_s_read_en = cmd & sel_read;
    assign o_s_byte_we = (cmd & ~sel_read) ? sel_be : 4'b0000;
    assign o_s_addr    = i_rst ? '0 : cmd ? sel_addr : addr_q;
    assign o_s_wdata   = i_rst ? '0 : cmd ? sel_wdata : wdata_q;

    assign rsp_on      = resp_valid & ~i_rst;
    assign o_m0_rvalid = rsp_on & ~resp_id;
    assign o_m1_rvalid = rsp_on & resp_id;
    assign o_m0_rdata  = (o_m0_rvalid & resp_read) ? i_s_rdata : '0;
    assign o_m1_rdata  = (o_m1_rvalid & resp_read) ? i_s_rdata : '0;

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        cnt_d   = cnt;
        if (locked) begin
            cnt_d = (cnt == '0) ? '0 : cnt - 1'b1;
            if (!sel_lock || cnt <= CW'(1)) begin
                state_d = ARB;
                ptr_d   = ~lock_id;
                cnt_d   = '0;
            end
        end else if (cmd) begin
            if (&req) ptr_d = ~gnt_id;
            if (sel_lock) begin
                state_d = gnt_id ? LOCKED1 : LOCKED0;
                cnt_d   = CW'(LOCK_MAX - 1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ARB;
            ptr        <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_read  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state      <= state_d;
            ptr        <= ptr_d;
            cnt        <= cnt_d;
            resp_valid <= cmd;
            resp_id    <= gnt_id;
            resp_read  <= sel_read;
            if (cmd) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
        end
    end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed-vector bench for the two-master MMIO arbiter.
module tb_mmio_arbiter;
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_m0_valid, i_m0_read, i_m0_lock, i_m1_valid, i_m1_read, i_m1_lock;
    logic [25:0] i_m0_addr, i_m1_addr;
    logic [31:0] i_m0_wdata, i_m1_wdata, i_s_rdata;
    logic [3:0]  i_m0_byte_we, i_m1_byte_we;
    logic        o_m0_ready, o_m0_rvalid, o_m1_ready, o_m1_rvalid, o_s_read_en;
    logic [31:0] o_m0_rdata, o_m1_rdata, o_s_wdata;
    logic [25:0] o_s_addr;
    logic [3:0]  o_s_byte_we;
    int n_checks = 0, n_fail = 0;
    int ack0 = 0, ack1 = 0;

    mmio_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(32), .LOCK_MAX(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_m0_valid(i_m0_valid), .i_m0_read(i_m0_read), .i_m0_addr(i_m0_addr),
        .i_m0_wdata(i_m0_wdata), .i_m0_byte_we(i_m0_byte_we), .i_m0_lock(i_m0_lock),
        .o_m0_ready(o_m0_ready), .o_m0_rvalid(o_m0_rvalid), .o_m0_rdata(o_m0_rdata),
        .i_m1_valid(i_m1_valid), .i_m1_read(i_m1_read), .i_m1_addr(i_m1_addr),
        .i_m1_wdata(i_m1_wdata), .i_m1_byte_we(i_m1_byte_we), .i_m1_lock(i_m1_lock),
        .o_m1_ready(o_m1_ready), .o_m1_rvalid(o_m1_rvalid), .o_m1_rdata(o_m1_rdata),
        .o_s_addr(o_s_addr), .o_s_wdata(o_s_wdata), .o_s_byte_we(o_s_byte_we),
        .o_s_read_en(o_s_read_en), .i_s_rdata(i_s_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle;
        i_m0_valid = 0; i_m0_read = 0; i_m0_addr = '0; i_m0_wdata = '0; i_m0_byte_we = '0; i_m0_lock = 0;
        i_m1_valid = 0; i_m1_read = 0; i_m1_addr = '0; i_m1_wdata = '0; i_m1_byte_we = '0; i_m1_lock = 0;
    endtask

    task automatic drive(input int m, input logic rd, input logic [25:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic lk);
        if (m == 0) begin
            i_m0_valid = 1; i_m0_read = rd; i_m0_addr = a; i_m0_wdata = d; i_m0_byte_we = be; i_m0_lock = lk;
        end else begin
            i_m1_valid = 1; i_m1_read = rd; i_m1_addr = a; i_m1_wdata = d; i_m1_byte_we = be; i_m1_lock = lk;
        end
    endtask

    initial begin
        idle();
        i_s_rdata = '0;
        drive(0, 1, 26'h1, 0, 0, 0);
        tick(); #1;
        check("rst_ready0", o_m0_ready, 0);
        check("rst_read_en", o_s_read_en, 0);
        check("rst_addr", o_s_addr, 0);
        check("rst_rvalid0", o_m0_rvalid, 0);
        tick(); idle(); i_rst = 0; #1;
        check("idle_read_en", o_s_read_en, 0);
        check("idle_byte_we", o_s_byte_we, 0);

        // single read from M0
        tick(); drive(0, 1, 26'h1, 0, 0, 0); #1;
        check("rd_ready0", o_m0_ready, 1);
        check("rd_ready1", o_m1_ready, 0);
        check("rd_read_en", o_s_read_en, 1);
        check("rd_addr", o_s_addr, 26'h1);
        check("rd_byte_we", o_s_byte_we, 0);
        tick(); idle(); i_s_rdata = 32'hA5A5_0001; #1;
        check("rd_rvalid0", o_m0_rvalid, 1);
        check("rd_rdata0", o_m0_rdata, 32'hA5A5_0001);
        check("rd_rvalid1", o_m1_rvalid, 0);
        check("rd_strobe_off", o_s_read_en, 0);
        check("rd_addr_hold", o_s_addr, 26'h1);
        tick(); i_s_rdata = '0; #1;
        check("rd_rvalid0_gone", o_m0_rvalid, 0);

        // both masters write: round-robin alternation
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i < 4) begin
                drive(0, 0, 26'h0, 32'h11, 4'hF, 0);
                drive(1, 0, 26'h6, 32'h22, 4'hF, 0);
            end else idle();
            #1;
            ack0 += int'(o_m0_rvalid);
            ack1 += int'(o_m1_rvalid);
            check("rr_wack_rdata", o_m0_rdata | o_m1_rdata, 0);
            if (i < 4) begin
                check("rr_ready0", o_m0_ready, (i % 2) == 0);
                check("rr_ready1", o_m1_ready, (i % 2) == 1);
                check("rr_addr", o_s_addr, (i % 2) ? 26'h6 : 26'h0);
                check("rr_wdata", o_s_wdata, (i % 2) ? 32'h22 : 32'h11);
                check("rr_byte_we", o_s_byte_we, 4'hF);
            end
        end
        check("rr_acks0", ack0, 2);
        check("rr_acks1", ack1, 2);

        // M0 lock: 16 consecutive grants, then M1
        for (int i = 0; i < 17; i++) begin
            tick(); drive(0, 1, 26'h3, 0, 0, 1); drive(1, 0, 26'h4, 32'h33, 4'hF, 0); #1;
            check("lock_ready0", o_m0_ready, i < 16);
            check("lock_ready1", o_m1_ready, i == 16);
        end
        tick(); idle(); #1;
        check("lock_m1_ack", o_m1_rvalid, 1);

        // M1 read then idle: no spurious strobes
        tick(); drive(1, 1, 26'h5, 0, 0, 0); #1;
        check("m1rd_ready1", o_m1_ready, 1);
        check("m1rd_read_en", o_s_read_en, 1);
        check("m1rd_addr", o_s_addr, 26'h5);
        for (int i = 0; i < 10; i++) begin
            tick(); idle(); i_s_rdata = (i == 0) ? 32'h5555 : 32'h0; #1;
            if (i == 0) begin
                check("m1rd_rvalid1", o_m1_rvalid, 1);
                check("m1rd_rdata1", o_m1_rdata, 32'h5555);
            end
            check("idle_no_read", o_s_read_en, 0);
            check("idle_no_we", o_s_byte_we, 0);
        end
        check("idle_addr_hold", o_s_addr, 26'h5);

        // reset right after a locked M0 read acceptance
        tick(); drive(0, 1, 26'h7, 0, 0, 1); drive(1, 1, 26'h8, 0, 0, 0); #1;
        check("mid_ready0", o_m0_ready, 1);
        tick(); idle(); i_rst = 1; #1;
        check("mid_rvalid0", o_m0_rvalid, 0);
        check("mid_rdata0", o_m0_rdata, 0);
        check("mid_read_en", o_s_read_en, 0);
        check("mid_addr", o_s_addr, 0);
        check("mid_wdata", o_s_wdata, 0);
        tick(); i_rst = 0; drive(1, 1, 26'h8, 0, 0, 0); #1;
        check("post_rvalid0", o_m0_rvalid, 0);
        check("post_unlock_ready1", o_m1_ready, 1);
        tick(); drive(0, 1, 26'h9, 0, 0, 0); #1;
        check("post_ptr_ready0", o_m0_ready, 1);
        check("post_ptr_ready1", o_m1_ready, 0);
        tick(); idle(); #1;

        // M1 partial-byte write
        tick(); drive(1, 0, 26'h2, 32'h00AB_0000, 4'b0100, 0); #1;
        check("bw_ready1", o_m1_ready, 1);
        check("bw_byte_we", o_s_byte_we, 4'b0100);
        check("bw_wdata", o_s_wdata, 32'h00AB_0000);
        check("bw_read_en", o_s_read_en, 0);
        tick(); idle(); #1;
        check("bw_we_off", o_s_byte_we, 0);
        check("bw_rvalid1", o_m1_rvalid, 1);
        check("bw_rdata1", o_m1_rdata, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_arbiter.md
Name: mmio_arbiter

Overview:
Two-master arbiter that shares the single memory-mapped peripheral slave (GPIO, UART FIFOs, millis counter at word addresses 0x0..0x8) between the CPU data port (master 0) and the debug/loader bridge (master 1). The slave takes a command in one cycle and returns read data in the next cycle.
The arbiter accepts at most one command per cycle using round-robin selection, with an optional master lock for atomic read-modify-write. It routes each response back to the master that issued the command.

Parameters:
ADDR_WIDTH, 26, word address width forwarded to the slave
DATA_WIDTH, 32, read/write data width
LOCK_MAX, 16, maximum consecutive cycles a master may hold the lock before it is forcibly released

Ports:
i_clk  input  1  clock; all logic on rising edge
i_rst  input  1  synchronous active-high reset
i_m0_valid  input  1  master 0 command valid
i_m0_read  input  1  1 = read, 0 = write
i_m0_addr  input  ADDR_WIDTH  master 0 word address
i_m0_wdata  input  DATA_WIDTH  master 0 write data
i_m0_byte_we  input  4  master 0 byte write enables (ignored when i_m0_read=1)
i_m0_lock  input  1  master 0 requests exclusive ownership
o_m0_ready  output  1  master 0 command accepted this cycle
o_m0_rvalid  output  1  master 0 response valid (reads and writes)
o_m0_rdata  output  DATA_WIDTH  master 0 read data
i_m1_* / o_m1_*  same set as master 0, for master 1
o_s_addr  output  ADDR_WIDTH  slave address
o_s_wdata  output  DATA_WIDTH  slave write data
o_s_byte_we  output  4  slave byte enables
o_s_read_en  output  1  slave read strobe
i_s_rdata  input  DATA_WIDTH  slave read data, valid the cycle after a read strobe

Behaviour:
- Reset values:
  - o_mX_ready=0, o_mX_rvalid=0, o_mX_rdata=0.
  - o_s_byte_we=0, o_s_read_en=0, o_s_addr=0, o_s_wdata=0.
  - Priority pointer = master 0; state = ARB; lock counter = 0.
- Command path is combinational from the registered grant state:
  - The granted master's addr/wdata drive the slave.
  - o_s_read_en = valid & read.
  - o_s_byte_we = valid & ~read ? byte_we : 0.
- No-command cycles: o_s_read_en=0 and o_s_byte_we=0, mandatory so the RX FIFO is never popped spuriously. o_s_addr holds its last value.
- o_mX_ready=1 only for the granted master, in the same cycle its valid is high. A command transfers when valid & ready.
- A master must hold its command stable until ready. A deasserted valid withdraws the request without any slave side effect.
- Response timing:
  - Every accepted command produces exactly one o_mX_rvalid pulse, exactly 1 cycle after acceptance.
  - Reads: rdata = i_s_rdata in that cycle.
  - Writes: rdata = 0.
  - The response owner and type are registered at acceptance.
- Throughput: back-to-back acceptance every cycle is allowed, because the response pipeline is depth 1.
- State ARB:
  - Only one master valid: that master is granted.
  - Both valid: the master indicated by the pointer is granted, and the pointer flips to the other master after acceptance.
  - Accepting a command with lock=1 moves to LOCKED0 or LOCKED1 (matching the master) and loads counter = LOCK_MAX-1.
- State LOCKEDn:
  - Only master n is granted; the other master's ready stays 0.
  - Counter decrements every cycle.
  - Exit to ARB when master n's lock=0 or the counter reaches 0. On exit the pointer is set to the other master.
- Simultaneous events:
  - Lock release and a new request from the other master in the same cycle: the other master is granted next cycle, not the same cycle.
  - Response from the previous command and acceptance of a new command in the same cycle: both happen.
- Reset mid-operation: a pending response is discarded (no rvalid after reset), the lock is dropped, and the slave strobes go low in the reset cycle.

Decomposition:
- Package mmio_arb_pkg:
  - typedef enum logic [1:0] {ARB, LOCKED0, LOCKED1} arb_state_t.
  - typedef logic master_id_t.
  - localparam NUM_MASTERS = 2.
- Sub-module mmio_rr_pick: combinational 2-way round-robin pick. Inputs: valid[1:0], pointer. Outputs: grant one-hot, grant id.

Test Plan:
- M0 read addr 0x1 with i_s_rdata=0xA5A5_0001 next cycle -> o_m0_ready same cycle, o_s_read_en=1 for 1 cycle, o_m0_rvalid=1 with rdata 0xA5A5_0001 one cycle later, o_m1_rvalid stays 0.
- Both masters hold valid writes (M0 addr 0x0 data 0x11, M1 addr 0x6 data 0x22) for 4 cycles -> grants alternate M0, M1, M0, M1; each gets exactly 2 write acks with rdata=0.
- M0 holds lock=1 with continuous requests while M1 is valid -> M0 granted exactly LOCK_MAX=16 consecutive cycles; M1 granted on cycle 17.
- Idle cycles after M1 read of addr 0x5 -> o_s_read_en exactly one cycle high; zero read strobes and byte_we=0 during 10 idle cycles.
- Assert i_rst in the cycle after M0 read acceptance -> no o_m0_rvalid, all outputs at reset values, state back to ARB with pointer = M0.
- M1 write with byte_we=4'b0100, data 0x00AB_0000 -> o_s_byte_we=4'b0100, o_s_wdata=0x00AB_0000 for one cycle, ack next cycle.
